// File: rtl/serial_addsub8.sv
// serial_addsub8 : bit-serial add/subtract unit, LSB first, start/done handshake.
//
// Ports
//    clk                 rising-edge clock
//    reset               synchronous, active-high reset
//    start               operation request, accepted when busy=0
//    op                  0 = a+b+carry_in, 1 = a-b-carry_in
//    a, b                WIDTH-bit operands (unsigned or two's complement)
//    carry_in            carry-in (add) / borrow-in (sub)
//    busy                high while bits are being processed
//    done                one-cycle pulse when a new result is presented
//    sum                 result, held until the next completion
//    carry_out           carry-out (add) / borrow-out (sub)
//    overflow_indicator  signed overflow of the last result
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start
// RUN     | processing one bit per clock, count_q = bit index
// DONE    | result just written; done high for this single cycle
module serial_addsub8 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow_indicator
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             op_q, op_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_out_q, carry_out_d;
   logic             ovf_q, ovf_d;

   logic a_bit, b_eff, s_bit, c_next;

   // Subtraction runs through the same adder as a + ~b + ~borrow_in.
   always_comb begin
      a_bit  = a_q[count_q];
      b_eff  = op_q ^ b_q[count_q];
      s_bit  = a_bit ^ b_eff ^ c_q;
      c_next = (a_bit & b_eff) | (a_bit & c_q) | (b_eff & c_q);
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      c_d         = c_q;
      shift_d     = shift_q;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
      ovf_d       = ovf_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               c_d     = op ^ carry_in;
               count_d = '0;
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // Result bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
            shift_d = {s_bit, shift_q[WIDTH-1:1]};
            c_d     = c_next;
            count_d = count_q + CW'(1);
            if (count_q == LAST_BIT) begin
               state_d     = ST_DONE;
               sum_d       = shift_d;
               // Adder carry is the inverse of the borrow when subtracting.
               carry_out_d = op_q ^ c_next;
               // c_q is the carry into the MSB, c_next the carry out of it.
               ovf_d       = c_q ^ c_next;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= 1'b0;
         c_q         <= 1'b0;
         shift_q     <= '0;
         sum_q       <= '0;
         carry_out_q <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         c_q         <= c_d;
         shift_q     <= shift_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
         ovf_q       <= ovf_d;
      end
   end

   assign busy               = (state_q == ST_RUN);
   assign done               = (state_q == ST_DONE);
   assign sum                = sum_q;
   assign carry_out          = carry_out_q;
   assign overflow_indicator = ovf_q;

endmodule

// File: tb/tb_serial_addsub8.sv
// tb_serial_addsub8 : scoreboard bench for serial_addsub8.
module tb_serial_addsub8;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       op;
   logic [7:0] a;
   logic [7:0] b;
   logic       carry_in;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       carry_out;
   logic       overflow_indicator;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct packed {
      logic [7:0] s;
      logic       co;
      logic       ov;
   } exp_t;

   typedef struct packed {
      logic       op;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
   } op_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   serial_addsub8 #(.WIDTH(8)) dut (
      .clk                (clk),
      .reset              (reset),
      .start              (start),
      .op                 (op),
      .a                  (a),
      .b                  (b),
      .carry_in           (carry_in),
      .busy               (busy),
      .done               (done),
      .sum                (sum),
      .carry_out          (carry_out),
      .overflow_indicator (overflow_indicator)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input logic o, input logic [7:0] x, input logic [7:0] y,
                                  input logic c);
      exp_t e;
      int   ux, uy, sx, sy, ci, r, sr;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      ci = c ? 1 : 0;
      if (!o) begin
         r    = ux + uy + ci;
         sr   = sx + sy + ci;
         e.co = (r > 255);
      end else begin
         r    = ux - uy - ci;
         sr   = sx - sy - ci;
         e.co = (ux < uy + ci);
      end
      e.s  = r[7:0];
      e.ov = (sr > 127) || (sr < -128);
      return e;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y, input logic c);
      start    = 1'b1;
      op       = o;
      a        = x;
      b        = y;
      carry_in = c;
      sb.push_back(model(o, x, y, c));
   endtask

   task automatic scramble_inputs;
      start    = 1'b0;
      op       = 1'($urandom_range(0, 1));
      a        = 8'($urandom_range(0, 255));
      b        = 8'($urandom_range(0, 255));
      carry_in = 1'($urandom_range(0, 1));
   endtask

   task automatic test_reset;
      reset = 1'b1;
      scramble_inputs();
      tick();
      tick();
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      n_total++; if (sum !== 8'h00) $display("FAIL reset_sum: got %h expected 00", sum); else n_pass++;
      n_total++; if (carry_out !== 1'b0) $display("FAIL reset_co: got %b expected 0", carry_out); else n_pass++;
      n_total++; if (overflow_indicator !== 1'b0) $display("FAIL reset_ov: got %b expected 0", overflow_indicator); else n_pass++;
      reset = 1'b0;
      tick();
      n_total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL idle_after_reset: busy=%b done=%b expected 0 0", busy, done); else n_pass++;
   endtask

   task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y, input logic c,
                         input string name);
      exp_t       e;
      int         n;
      logic [7:0] prev;
      prev = sum;
      issue(o, x, y, c);
      tick();
      scramble_inputs();
      n_total++; if (busy !== 1'b1) $display("FAIL %s_busy: got %b expected 1", name, busy); else n_pass++;
      n = 0;
      while (done !== 1'b1 && n < 20) begin
         tick();
         n++;
         if (done !== 1'b1) begin
            n_total++;
            if (sum !== prev) $display("FAIL %s_sum_stable: got %h expected %h", name, sum, prev);
            else n_pass++;
         end
      end
      n_total++; if (n != 8) $display("FAIL %s_latency: got %0d expected 8", name, n); else n_pass++;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s_scoreboard: got empty queue expected one entry", name);
      end else begin
         e = sb.pop_front();
         if (done === 1'b1) begin
            n_total++; if (sum !== e.s) $display("FAIL %s_sum: got %h expected %h", name, sum, e.s); else n_pass++;
            n_total++; if (carry_out !== e.co) $display("FAIL %s_co: got %b expected %b", name, carry_out, e.co); else n_pass++;
            n_total++; if (overflow_indicator !== e.ov) $display("FAIL %s_ov: got %b expected %b", name, overflow_indicator, e.ov); else n_pass++;
         end
      end
      tick();
      n_total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_done_pulse: busy=%b done=%b expected 0 0", name, busy, done); else n_pass++;
   endtask

   task automatic test_basic;
      run_op(1'b0, 8'd200, 8'd100, 1'b0, "add_200_100");
      run_op(1'b1, 8'd5,   8'd10,  1'b0, "sub_5_10");
      run_op(1'b1, 8'h80,  8'h01,  1'b0, "sub_ovf");
      run_op(1'b0, 8'h7F,  8'h01,  1'b0, "add_ovf");
      run_op(1'b0, 8'hFF,  8'h00,  1'b1, "add_cin_wrap");
      run_op(1'b1, 8'h00,  8'h00,  1'b1, "sub_bin_wrap");
      run_op(1'b1, 8'h37,  8'h12,  1'b1, "sub_plain");
   endtask

   task automatic test_ignore_start;
      exp_t e;
      int   pulses;
      issue(1'b0, 8'd1, 8'd1, 1'b0);
      tick();
      start = 1'b0;
      tick();
      tick();
      start    = 1'b1;
      op       = 1'b1;
      a        = 8'd9;
      b        = 8'd9;
      carry_in = 1'b1;
      tick();
      start  = 1'b0;
      e      = sb.pop_front();
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) begin
            pulses++;
            n_total++; if (sum !== e.s) $display("FAIL ignore_sum: got %h expected %h", sum, e.s); else n_pass++;
            n_total++; if (carry_out !== e.co) $display("FAIL ignore_co: got %b expected %b", carry_out, e.co); else n_pass++;
         end
         tick();
      end
      n_total++; if (pulses != 1) $display("FAIL ignore_pulses: got %0d expected 1", pulses); else n_pass++;
   endtask

   task automatic test_reset_abort;
      int pulses;
      run_op(1'b0, 8'h80, 8'h81, 1'b0, "pre_abort");
      issue(1'b0, 8'h33, 8'h44, 1'b1);
      tick();
      start = 1'b0;
      void'(sb.pop_back());
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL abort_done: got %b expected 0", done); else n_pass++;
      n_total++; if (sum !== 8'h00) $display("FAIL abort_sum: got %h expected 00", sum); else n_pass++;
      n_total++; if (carry_out !== 1'b0) $display("FAIL abort_co: got %b expected 0", carry_out); else n_pass++;
      n_total++; if (overflow_indicator !== 1'b0) $display("FAIL abort_ov: got %b expected 0", overflow_indicator); else n_pass++;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      n_total++; if (pulses != 0) $display("FAIL abort_no_done: got %0d expected 0", pulses); else n_pass++;
      run_op(1'b1, 8'h10, 8'h20, 1'b1, "post_abort");
   endtask

   task automatic test_back_to_back;
      op_t  q[$];
      op_t  cur;
      exp_t e;
      int   n;
      logic [7:0] vals[$];
      for (int v = 0; v < 256; v += 17) vals.push_back(8'(v));
      vals.push_back(8'h01);
      vals.push_back(8'h7F);
      vals.push_back(8'h80);
      vals.push_back(8'hFE);
      foreach (vals[i])
         foreach (vals[j])
            for (int k = 0; k < 4; k++) begin
               cur.op  = 1'(k >> 1);
               cur.cin = 1'(k & 1);
               cur.a   = vals[i];
               cur.b   = vals[j];
               q.push_back(cur);
            end
      for (int r = 0; r < 200; r++) begin
         cur.op  = 1'($urandom_range(0, 1));
         cur.cin = 1'($urandom_range(0, 1));
         cur.a   = 8'($urandom_range(0, 255));
         cur.b   = 8'($urandom_range(0, 255));
         q.push_back(cur);
      end
      cur = q.pop_front();
      issue(cur.op, cur.a, cur.b, cur.cin);
      tick();
      scramble_inputs();
      while (1) begin
         n = 0;
         while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         n_total++;
         if (n != 8) begin
            $display("FAIL b2b_latency: got %0d expected 8", n);
            break;
         end
         n_pass++;
         e = sb.pop_front();
         n_total++; if (sum !== e.s) $display("FAIL b2b_sum: got %h expected %h", sum, e.s); else n_pass++;
         n_total++; if (carry_out !== e.co) $display("FAIL b2b_co: got %b expected %b", carry_out, e.co); else n_pass++;
         n_total++; if (overflow_indicator !== e.ov) $display("FAIL b2b_ov: got %b expected %b", overflow_indicator, e.ov); else n_pass++;
         if (q.size() == 0) break;
         cur = q.pop_front();
         issue(cur.op, cur.a, cur.b, cur.cin);
         tick();
         scramble_inputs();
         n_total++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done); else n_pass++;
      end
      tick();
      n_total++; if (done !== 1'b0) $display("FAIL b2b_final_done: got %b expected 0", done); else n_pass++;
      n_total++; if (sb.size() != 0) $display("FAIL b2b_scoreboard_left: got %0d expected 0", sb.size()); else n_pass++;
      sb.delete();
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      op       = 1'b0;
      a        = 8'h00;
      b        = 8'h00;
      carry_in = 1'b0;
      test_reset();
      test_basic();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
